// File: rtl/display_scan_scheduler.sv
// Time-multiplexed 4-digit seven-segment scanner with double-buffered patterns,
// per-digit masking, 16-level brightness and a one-cycle ghost blank at slot start.
module display_scan_scheduler #(
  parameter int unsigned SUB_DIV = 6250
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [3:0]  brightness,
  input  logic [3:0]  digit_en,
  input  logic        wr_valid,
  input  logic [27:0] wr_data,
  output logic        wr_ready,
  output logic [3:0]  an,
  output logic [6:0]  sseg,
  output logic        frame_done
);

  localparam int unsigned PW = (SUB_DIV > 1) ? $clog2(SUB_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(SUB_DIV - 1);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_SCAN = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [PW-1:0]    presc_q, presc_d;
  logic [3:0]       sub_q, sub_d;
  logic [1:0]       digit_q, digit_d;
  logic [3:0]       bright_q, bright_d;
  logic [27:0]      pending_q, pending_d;
  logic             pend_q, pend_d;
  logic [3:0][6:0]  active_q, active_d;
  logic [3:0]       an_q, an_d;
  logic [6:0]       sseg_q, sseg_d;
  logic             frame_done_q, frame_done_d;

  logic presc_last;
  logic boundary;
  logic slot_start;
  logic lit;

  always_comb begin
    presc_last = (presc_q == PRESC_MAX);
    boundary   = (state_q == ST_SCAN) && (digit_q == 2'd3) && (sub_q == 4'hF) && presc_last;

    state_d = state_q;
    presc_d = presc_q;
    sub_d   = sub_q;
    digit_d = digit_q;

    case (state_q)
      ST_IDLE: begin
        presc_d = '0;
        sub_d   = 4'd0;
        digit_d = 2'd0;
        if (enable) state_d = ST_SCAN;
      end
      ST_SCAN: begin
        if (!enable) begin
          state_d = ST_IDLE;
          presc_d = '0;
          sub_d   = 4'd0;
          digit_d = 2'd0;
        end else if (presc_last) begin
          presc_d = '0;
          sub_d   = sub_q + 4'd1;
          if (sub_q == 4'hF) digit_d = digit_q + 2'd1;
        end else begin
          presc_d = presc_q + PW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    bright_d = ((state_q == ST_SCAN) && (sub_q == 4'd0) && (presc_q == '0)) ? brightness : bright_q;

    // Commit and accept are exclusive: a commit needs pend set, which holds wr_ready low.
    pend_d    = pend_q;
    pending_d = pending_q;
    active_d  = active_q;
    if (pend_q && (boundary || (state_q == ST_IDLE))) begin
      active_d = pending_q;
      pend_d   = 1'b0;
    end
    if (wr_valid && !pend_q) begin
      pending_d = wr_data;
      pend_d    = 1'b1;
    end

    // Outputs decode the post-edge counters, so the slot's first cycle is the ghost blank.
    slot_start = (state_d == ST_SCAN) && (sub_d == 4'd0) && (presc_d == '0);
    lit        = (state_d == ST_SCAN) && !slot_start && digit_en[digit_d] && (sub_d <= bright_d);

    an_d   = 4'hF;
    sseg_d = 7'h7F;
    if (lit) begin
      an_d[digit_d] = 1'b0;
      sseg_d        = active_d[digit_d];
    end

    frame_done_d = boundary && enable;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      presc_q      <= '0;
      sub_q        <= 4'd0;
      digit_q      <= 2'd0;
      bright_q     <= 4'd0;
      pending_q    <= '0;
      pend_q       <= 1'b0;
      active_q     <= {4{7'h7F}};
      an_q         <= 4'hF;
      sseg_q       <= 7'h7F;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      presc_q      <= presc_d;
      sub_q        <= sub_d;
      digit_q      <= digit_d;
      bright_q     <= bright_d;
      pending_q    <= pending_d;
      pend_q       <= pend_d;
      active_q     <= active_d;
      an_q         <= an_d;
      sseg_q       <= sseg_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign wr_ready   = ~pend_q;
  assign an         = an_q;
  assign sseg       = sseg_q;
  assign frame_done = frame_done_q;

endmodule
